elevator_motion_ctrl: RTL and testbench

Downstream consumer of the floor-request queue head (Pos0). Latches the head request and drives the car floor by floor with timed travel. Opens the door at the target, then pulses deletePos0 so the queue advances. Sits between the request memory and the motor/door drivers and floor display.

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/elevator_timer.sv | 41 ++++
 rtl/elevator_motion_ctrl.sv | 163 ++++++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator motion controller and its helpers.
package elevator_pkg;

  localparam int FLOOR_W_DEF    = 2;
  localparam int NUM_FLOORS_DEF = 4;

  typedef logic [FLOOR_W_DEF-1:0] floor_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR      = 3'd3,
    RELEASE   = 3'd4,
    SETTLE    = 3'd5
  } state_e;

  // Width able to hold max(a,b)-1, never narrower than one bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter with zero flag; parks at zero until reloaded.
module elevator_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority over counting; the counter never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == {W{1'b0}});

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Services the request-queue head: travels floor by floor, opens the door, pops the queue.
// Optional macro DOOR_SENSOR_EN adds doorBlocked, which holds the door open while asserted.
module elevator_motion_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int FLOOR_W       = FLOOR_W_DEF,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef DOOR_SENSOR_EN
  input  logic               doorBlocked,
`endif
  input  logic [FLOOR_W-1:0] Pos0,
  input  logic               Pos0_Valid,
  output logic               deletePos0,
  output logic [FLOOR_W-1:0] currentFloor,
  output logic               motorUp,
  output logic               motorDown,
  output logic               doorOpen,
  output logic               busy
);

  localparam int                 TW           = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [TW-1:0]      TRAVEL_LOAD  = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]      DOOR_LOAD    = TW'(DOOR_CYCLES - 1);
  localparam logic [31:0]        NUM_FLOORS_U = NUM_FLOORS;
  localparam logic [FLOOR_W-1:0] FLOOR_ONE    = FLOOR_W'(1);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] target_q, target_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               motor_up_q, motor_up_d;
  logic               motor_down_q, motor_down_d;
  logic               door_open_q, door_open_d;
  logic               delete_q, delete_d;
  logic               busy_q, busy_d;

  logic               tmr_en, tmr_load, tmr_zero;
  logic [TW-1:0]      tmr_val, tmr_count;

  elevator_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tmr_en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    floor_d  = floor_q;
    tmr_en   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = {TW{1'b0}};
    case (state_q)
      IDLE: begin
        if (!Pos0_Valid) begin
          state_d = IDLE;
        end else if (32'(Pos0) >= NUM_FLOORS_U) begin
          state_d = RELEASE;
        end else if (Pos0 > floor_q) begin
          target_d = Pos0;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_LOAD;
          state_d  = MOVE_UP;
        end else if (Pos0 < floor_q) begin
          target_d = Pos0;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_LOAD;
          state_d  = MOVE_DOWN;
        end else begin
          target_d = Pos0;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
          state_d  = DOOR;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          floor_d  = (state_q == MOVE_UP) ? (floor_q + FLOOR_ONE) : (floor_q - FLOOR_ONE);
          tmr_load = 1'b1;
          if (floor_d == target_q) begin
            tmr_val = DOOR_LOAD;
            state_d = DOOR;
          end else begin
            tmr_val = TRAVEL_LOAD;
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      DOOR: begin
        tmr_en = 1'b1;
`ifdef DOOR_SENSOR_EN
        if (doorBlocked) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
          state_d  = DOOR;
        end else if (tmr_zero) begin
          state_d = RELEASE;
        end else begin
          state_d = DOOR;
        end
`else
        if (tmr_zero) begin
          state_d = RELEASE;
        end else begin
          state_d = DOOR;
        end
`endif
      end
      RELEASE: state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    motor_up_d   = (state_d == MOVE_UP);
    motor_down_d = (state_d == MOVE_DOWN);
    door_open_d  = (state_d == DOOR);
    delete_d     = (state_d == RELEASE);
    busy_d       = (state_d != IDLE);
  end

  // State, position and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= {FLOOR_W{1'b0}};
      floor_q      <= {FLOOR_W{1'b0}};
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
      delete_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      floor_q      <= floor_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      door_open_q  <= door_open_d;
      delete_q     <= delete_d;
      busy_q       <= busy_d;
    end
  end

  assign deletePos0   = delete_q;
  assign currentFloor = floor_q;
  assign motorUp      = motor_up_q;
  assign motorDown    = motor_down_q;
  assign doorOpen     = door_open_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Randomized queue-driven bench: a FIFO model feeds Pos0, a scoreboard checks each serviced request.
module tb_elevator_motion_ctrl;
  import elevator_pkg::*;

  localparam int NF   = 4;
  localparam int TC   = 4;
  localparam int DC   = 3;
  localparam int NREQ = 40;
`ifdef DOOR_SENSOR_EN
  localparam int DOOR_EXP = DC + 6;
`else
  localparam int DOOR_EXP = DC;
`endif

  typedef struct {
    int up_cyc;
    int dn_cyc;
    int door_cyc;
    int steps;
    int floor;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  floor_t Pos0;
  logic   Pos0_Valid;
  logic   deletePos0, motorUp, motorDown, doorOpen, busy;
  floor_t currentFloor;
`ifdef DOOR_SENSOR_EN
  logic   doorBlocked;
`endif

  elevator_motion_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(2), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef DOOR_SENSOR_EN
    .doorBlocked(doorBlocked),
`endif
    .Pos0(Pos0),
    .Pos0_Valid(Pos0_Valid),
    .deletePos0(deletePos0),
    .currentFloor(currentFloor),
    .motorUp(motorUp),
    .motorDown(motorDown),
    .doorOpen(doorOpen),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  int   req_q[$];
  exp_t exp_q[$];
  int   model_floor = 0;
  int   pushed = 0;
  bit   gen_en = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Driver: request FIFO model, Pos0 presentation, garbage on Pos0 while the car is busy.
  initial begin
    int   tgt, diff, dcnt;
    exp_t e;
    dcnt = 0;
    forever begin
      @(negedge clk);
      if (deletePos0 && req_q.size() > 0) void'(req_q.pop_front());
      if (gen_en && pushed < NREQ && req_q.size() < 4 && $urandom_range(3) == 0) begin
        tgt  = $urandom_range(NF - 1);
        diff = tgt - model_floor;
        e.up_cyc   = (diff > 0) ? diff * TC : 0;
        e.dn_cyc   = (diff < 0) ? -diff * TC : 0;
        e.door_cyc = DOOR_EXP;
        e.steps    = (diff < 0) ? -diff : diff;
        e.floor    = tgt;
        exp_q.push_back(e);
        req_q.push_back(tgt);
        model_floor = tgt;
        pushed++;
      end
      if (busy) begin
        Pos0       = floor_t'($urandom_range(NF - 1));
        Pos0_Valid = 1'($urandom_range(1));
      end else begin
        Pos0       = (req_q.size() > 0) ? floor_t'(req_q[0]) : floor_t'($urandom_range(NF - 1));
        Pos0_Valid = (req_q.size() > 0);
      end
      dcnt = doorOpen ? dcnt + 1 : 0;
`ifdef DOOR_SENSOR_EN
      doorBlocked = (dcnt >= 2 && dcnt <= 6);
`endif
    end
  end

  // Monitor: per-cycle invariants and a scoreboard compare on every delete pulse.
  initial begin
    int   up_c, dn_c, door_c, steps, run, prev_floor, d;
    bit   prev_del, prev2_del;
    exp_t e;
    up_c = 0; dn_c = 0; door_c = 0; steps = 0; run = 0; prev_floor = 0;
    prev_del = 1'b0; prev2_del = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("motion_exclusive", (int'(motorUp) + int'(motorDown) + int'(doorOpen)) > 1, 0);
        check("delete_single", int'(prev_del & deletePos0), 0);
        if (prev_del) begin
          check("settle_busy", int'(busy), 1);
          check("settle_quiet", int'(motorUp | motorDown | doorOpen | deletePos0), 0);
        end
        if (prev2_del) check("idle_after_settle", int'(busy), 0);
        if (int'(currentFloor) != prev_floor) begin
          d = int'(currentFloor) - prev_floor;
          steps++;
          check("step_size", (d < 0) ? -d : d, 1);
          check("step_time", run, TC);
          run = 0;
        end
        run    += int'(motorUp | motorDown);
        up_c   += int'(motorUp);
        dn_c   += int'(motorDown);
        door_c += int'(doorOpen);
        if (deletePos0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_delete", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("up_cycles", up_c, e.up_cyc);
            check("down_cycles", dn_c, e.dn_cyc);
            check("door_cycles", door_c, e.door_cyc);
            check("floor_steps", steps, e.steps);
            check("arrive_floor", int'(currentFloor), e.floor);
          end
          up_c = 0; dn_c = 0; door_c = 0; steps = 0; run = 0;
        end
        prev2_del  = prev_del;
        prev_del   = deletePos0;
        prev_floor = int'(currentFloor);
      end
    end
  end

  initial begin
    int  cyc;
    bit  hit;
    rst_n      = 1'b0;
    Pos0       = '0;
    Pos0_Valid = 1'b0;
`ifdef DOOR_SENSOR_EN
    doorBlocked = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_motorUp", int'(motorUp), 0);
    check("rst_motorDown", int'(motorDown), 0);
    check("rst_doorOpen", int'(doorOpen), 0);
    check("rst_deletePos0", int'(deletePos0), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_floor", int'(currentFloor), 0);

    @(posedge clk);
    mon_en = 1'b1;
    gen_en = 1'b1;
    cyc = 0;
    while (!(pushed == NREQ && exp_q.size() == 0 && !busy && req_q.size() == 0) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check("drain_in_time", int'(cyc < 20000), 1);
    check("all_serviced", exp_q.size(), 0);

    // Asynchronous reset while moving up from floor 1.
    mon_en = 1'b0;
    gen_en = 1'b0;
    @(posedge clk);
    #1;
    req_q.push_back(1);
    req_q.push_back(3);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = motorUp && (currentFloor == floor_t'(1));
    end
    check("reach_up_from_1", int'(hit), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_motorUp", int'(motorUp), 0);
    check("midrst_floor", int'(currentFloor), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_delete", int'(deletePos0), 0);
    check("midrst_door", int'(doorOpen), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
